// File: rtl/button_debounce_if.sv
// Debounced-button bundle: raw pin levels in, clean levels and edge pulses out.
// The debouncer drives the master side; button-consuming logic uses the slave side.
interface button_debounce_if #(
  parameter int BN = 2
);
  logic [BN-1:0] btn_raw;
  logic [BN-1:0] btn;
  logic [BN-1:0] btn_pdg;
  logic [BN-1:0] btn_ndg;

  modport master (input btn_raw, output btn, btn_pdg, btn_ndg);
  modport slave  (input btn, btn_pdg, btn_ndg);
endinterface

// File: rtl/button_debounce.sv
// Per-button synchronizer + stability counter + 4-state FSM producing clean levels and edge pulses.
// Optional auto-repeat of press pulses while held: define BUTTON_DEBOUNCE_REPEAT_EN.
module button_debounce #(
  parameter int BN  = 2,
  parameter int DPN = 1024,
  parameter int DPL = $clog2(DPN),
  parameter int RDN = 4096,
  parameter int RPN = 1024
) (
  input logic               clk,
  input logic               rst,
  button_debounce_if.master bus
);

  typedef enum logic [1:0] {STB_LO, CHK_HI, STB_HI, CHK_LO} state_t;

  localparam logic [DPL-1:0] CNT_LAST = DPL'(DPN - 1);

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int RMX = (RDN > RPN) ? RDN : RPN;
  localparam int RW  = $clog2(RMX);
  localparam logic [RW-1:0] RD_LAST = RW'(RDN - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(RPN - 1);
`endif

  if (DPN < 2 || DPN > (1 << 20) || RDN < 2 || RPN < 1) begin : g_param_chk
    $error("button_debounce: illegal parameter value");
  end

  logic [BN-1:0] s1, s2;
  logic [BN-1:0] lvl, pdg, ndg;

  // Two-flop synchronizer: the FSMs only ever look at s2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < BN; i++) begin : g_bit
    state_t         st;
    logic [DPL-1:0] cnt;
    logic           lvl_q, pdg_q, ndg_q;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    logic [RW-1:0]  rpt;
    logic           rpt_first;
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st    <= STB_LO;
        cnt   <= '0;
        lvl_q <= 1'b0;
        pdg_q <= 1'b0;
        ndg_q <= 1'b0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        rpt       <= '0;
        rpt_first <= 1'b1;
`endif
      end else begin
        pdg_q <= 1'b0;
        ndg_q <= 1'b0;
        unique case (st)
          STB_LO: begin
            cnt <= '0;
            if (s2[i]) st <= CHK_HI;
          end
          CHK_HI: begin
            // Any reversal abandons the attempt; the count restarts from zero next time
            if (!s2[i]) st <= STB_LO;
            else if (cnt != CNT_LAST) cnt <= cnt + DPL'(1);
            else begin
              st    <= STB_HI;
              lvl_q <= 1'b1;
              pdg_q <= 1'b1;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
              rpt       <= '0;
              rpt_first <= 1'b1;
`endif
            end
          end
          STB_HI: begin
            cnt <= '0;
            if (!s2[i]) begin
              st <= CHK_LO;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
              rpt <= '0;
`endif
            end
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
            // First repeat after RDN cycles, then every RPN cycles
            else if (rpt == (rpt_first ? RD_LAST : RP_LAST)) begin
              pdg_q     <= 1'b1;
              rpt       <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt <= rpt + RW'(1);
            end
`endif
          end
          CHK_LO: begin
            if (s2[i]) begin
              st <= STB_HI;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
              rpt       <= '0;
              rpt_first <= 1'b1;
`endif
            end else if (cnt != CNT_LAST) cnt <= cnt + DPL'(1);
            else begin
              st    <= STB_LO;
              lvl_q <= 1'b0;
              ndg_q <= 1'b1;
            end
          end
          default: st <= STB_LO;
        endcase
      end
    end

    assign lvl[i] = lvl_q;
    assign pdg[i] = pdg_q;
    assign ndg[i] = ndg_q;
  end

  assign bus.btn     = lvl;
  assign bus.btn_pdg = pdg;
  assign bus.btn_ndg = ndg;

endmodule

// File: tb/tb_button_debounce.sv
// Directed + randomized bench for button_debounce against a sliding-window reference model.
// Expected repeat behaviour follows BUTTON_DEBOUNCE_REPEAT_EN.
module tb_button_debounce;
  localparam int BN  = 2;
  localparam int DPN = 8;
  localparam int RDN = 32;
  localparam int RPN = 8;
  localparam int LAT = DPN + 2;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int EXP_RPT = 1 + ((80 - RDN) / RPN + 1);
`else
  localparam int EXP_RPT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  button_debounce_if #(.BN(BN)) bus ();

  button_debounce #(.BN(BN), .DPN(DPN), .RDN(RDN), .RPN(RPN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a level is accepted once the synchronized input (raw delayed two
  // edges) has shown the opposite value for DPN+1 consecutive edges.
  logic [BN-1:0]  mb, pe, ne;
  logic [DPN+2:0] hist [BN];
  int             age [BN];
  int             cnt_pdg [BN];
  int             cnt_ndg [BN];

  task automatic chk(input string tag, input logic [BN-1:0] obs, input logic [BN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic seen;
    if (!rst) begin
      mb = '0; pe = '0; ne = '0;
      for (int b = 0; b < BN; b++) begin
        hist[b] = '0;
        age[b]  = -1;
      end
    end else begin
      for (int b = 0; b < BN; b++) begin
        hist[b] = {hist[b][DPN+1:0], bus.btn_raw[b]};
        seen    = hist[b][2];
        pe[b]   = 1'b0;
        ne[b]   = 1'b0;
        if (hist[b][DPN+2:2] == {(DPN+1){~mb[b]}}) begin
          mb[b] = ~mb[b];
          if (mb[b]) begin pe[b] = 1'b1; age[b] = 0; end
          else begin ne[b] = 1'b1; age[b] = -1; end
        end else if (mb[b]) begin
          if (!seen) age[b] = -1;
          else if (age[b] < 0) age[b] = 0;
          else begin
            age[b]++;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
            if (age[b] >= RDN && (age[b] - RDN) % RPN == 0) pe[b] = 1'b1;
`endif
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("btn", bus.btn, mb);
    chk("btn_pdg", bus.btn_pdg, pe);
    chk("btn_ndg", bus.btn_ndg, ne);
    chk("pdg_and_ndg", bus.btn_pdg & bus.btn_ndg, '0);
    for (int b = 0; b < BN; b++) begin
      cnt_pdg[b] += int'(bus.btn_pdg[b]);
      cnt_ndg[b] += int'(bus.btn_ndg[b]);
    end
  endtask

  task automatic ticks(input logic [BN-1:0] raw, input int n);
    bus.btn_raw = raw;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clr_cnt();
    for (int b = 0; b < BN; b++) begin
      cnt_pdg[b] = 0;
      cnt_ndg[b] = 0;
    end
  endtask

  // Drives raw for n edges; reports the first edge index (0 = first sampling edge) where btn[b]==lvl
  task automatic hold_measure(input logic [BN-1:0] raw, input int n, input int b, input logic lvl,
                              output int idx, output logic [BN-1:0] pdg_at, output logic [BN-1:0] ndg_at);
    bus.btn_raw = raw;
    idx = -1; pdg_at = '0; ndg_at = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (idx < 0 && bus.btn[b] === lvl) begin
        idx    = k;
        pdg_at = bus.btn_pdg;
        ndg_at = bus.btn_ndg;
      end
    end
  endtask

  initial begin
    int idx, left;
    logic [BN-1:0] pa, na, raw;
    int bnc [4];
    bnc = '{3, 2, 5, 1};
    clr_cnt();

    // Reset held with both buttons pressed
    rst = 1'b0;
    ticks(2'b11, 4);
    chk("rst_btn", bus.btn, 2'b00);
    chk("rst_pdg", bus.btn_pdg, 2'b00);
    chk("rst_ndg", bus.btn_ndg, 2'b00);

    // Release reset with buttons still held
    rst = 1'b1;
    hold_measure(2'b11, 20, 0, 1'b1, idx, pa, na);
    chk_int("rel_rise_edge", idx, LAT);
    chk("rel_pdg", pa, 2'b11);

    // Clean press / release on bit0
    ticks(2'b00, 20);
    hold_measure(2'b01, 20, 0, 1'b1, idx, pa, na);
    chk_int("press_rise_edge", idx, LAT);
    chk("press_pdg", pa, 2'b01);
    hold_measure(2'b00, 20, 0, 1'b0, idx, pa, na);
    chk_int("release_fall_edge", idx, LAT);
    chk("release_ndg", na, 2'b01);

    // Bounce: 3 hi, 2 lo, 5 hi, 1 lo, then held high
    clr_cnt();
    for (int j = 0; j < 4; j++) ticks((j % 2 == 0) ? 2'b01 : 2'b00, bnc[j]);
    hold_measure(2'b01, 20, 0, 1'b1, idx, pa, na);
    chk_int("bounce_rise_edge", idx, LAT);
    chk_int("bounce_pdg_count", cnt_pdg[0], 1);
    chk_int("bounce_ndg_count", cnt_ndg[0], 0);

    // Glitch on bit1: 7 cycles high is too short
    clr_cnt();
    ticks(2'b11, 7);
    ticks(2'b01, 20);
    chk_int("glitch_pdg_count", cnt_pdg[1], 0);
    chk_int("glitch_ndg_count", cnt_ndg[1], 0);
    chk("glitch_btn", bus.btn, 2'b01);

    // Independence: simultaneous press, then bit1 release while bit0 bounces
    ticks(2'b00, 20);
    hold_measure(2'b11, 20, 0, 1'b1, idx, pa, na);
    chk_int("both_rise_edge", idx, LAT);
    chk("both_pdg", pa, 2'b11);
    clr_cnt();
    raw = 2'b01; left = 0; idx = -1; na = '0;
    for (int k = 0; k < 20; k++) begin
      if (k < 12) begin
        if (left == 0) begin raw[0] = ~raw[0]; left = $urandom_range(1, 3); end
        left--;
      end else raw[0] = 1'b1;
      bus.btn_raw = raw;
      tick();
      if (idx < 0 && bus.btn[1] === 1'b0) begin idx = k; na = bus.btn_ndg; end
    end
    chk_int("indep_fall_edge", idx, LAT);
    chk("indep_ndg", na, 2'b10);
    chk_int("indep_bit0_ndg", cnt_ndg[0], 0);
    chk_int("indep_bit1_ndg", cnt_ndg[1], 1);

    // Reset in the middle of a check discards it; held button re-debounces from release
    ticks(2'b00, 20);
    ticks(2'b01, 5);
    rst = 1'b0;
    ticks(2'b01, 2);
    chk("midrst_btn", bus.btn, 2'b00);
    rst = 1'b1;
    hold_measure(2'b01, 20, 0, 1'b1, idx, pa, na);
    chk_int("midrst_rise_edge", idx, LAT);

    // Long hold: auto-repeat (if built in) then silence after release
    ticks(2'b00, 30);
    clr_cnt();
    hold_measure(2'b01, LAT + 81, 0, 1'b1, idx, pa, na);
    chk_int("hold_rise_edge", idx, LAT);
    chk_int("hold_pdg_count", cnt_pdg[0], EXP_RPT);
    clr_cnt();
    ticks(2'b00, 40);
    chk_int("after_release_pdg", cnt_pdg[0], 0);
    chk_int("after_release_ndg", cnt_ndg[0], 1);

    // Randomized raw levels with varied run lengths
    raw = bus.btn_raw;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < BN; b++)
        if ($urandom_range(0, 11) == 0) raw[b] = ~raw[b];
      bus.btn_raw = raw;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions raw mechanical push-button inputs into clean, debounced levels plus single-cycle edge pulses.
- Sits between board pins and button-consuming logic. It is the producer side of the "debounced button" interface that the stopwatch run/clear inputs consume.
- Each button has its own synchronizer, its own stability counter and its own 4-state FSM.

Parameters:
- BN, 2, number of buttons.
- DPN, 1024, debounce period in clk cycles; a new level must be stable this long. Legal range 2 to 2^20.
- DPL, $clog2(DPN), debounce counter width.
- RDN, 4096, auto-repeat initial delay in cycles. Used only with the optional feature.
- RPN, 1024, auto-repeat period in cycles. Used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- btn_raw  input  BN  raw asynchronous button levels, 1 = pressed.
- btn  output  BN  debounced level per button.
- btn_pdg  output  BN  one-cycle pulse on debounced press (0->1).
- btn_ndg  output  BN  one-cycle pulse on debounced release (1->0).

Behaviour:
- Reset (rst=0, asynchronous) clears: sync flops 0, every FSM in STB_LO, counters 0, btn=0, btn_pdg=0, btn_ndg=0. All outputs are registered.
- Synchronizer: 2 flops per bit (s1, s2). The FSM sees only s2.
- FSM states per button: STB_LO, CHK_HI, STB_HI, CHK_LO.
- STB_LO:
  - s2=1 -> CHK_HI, cnt<=0.
  - Otherwise stay; cnt held at 0.
- CHK_HI:
  - s2=0 -> STB_LO, no output change (glitch rejected).
  - s2=1 and cnt!=DPN-1 -> cnt<=cnt+1.
  - s2=1 and cnt==DPN-1 -> STB_HI, btn<=1, btn_pdg<=1 for exactly one cycle.
- STB_HI / CHK_LO: mirror of the above. On acceptance: STB_LO, btn<=0, btn_ndg<=1 for one cycle.
- Latency: define edge 0 as the first clk edge that samples the new raw level. With the level stable, btn changes at edge DPN+2, and the pulse is asserted in the same cycle btn changes.
- A glitch shorter than DPN cycles of stable s2 never changes btn. Any reversal during CHK restarts the count on the next attempt, so partial stability is not accumulated.
- btn_pdg and btn_ndg are never both 1 for the same bit. No back-to-back pulses on a bit: the minimum spacing is DPN+1 cycles.
- Buttons are fully independent. Simultaneous presses on several bits produce pulses in the same cycle.
- cnt never exceeds DPN-1. No wrap-around is possible.
- Reset mid-CHK discards the pending transition. A button held through reset release produces btn_pdg DPN+2 cycles after the first sampling edge following reset deassertion.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_REPEAT_EN.
- Defined:
  - Each bit gets a repeat counter of width $clog2(max(RDN,RPN)), cleared on entry to STB_HI.
  - While in STB_HI, an extra one-cycle btn_pdg pulse is emitted RDN cycles after the btn rising edge, then every RPN cycles.
  - Leaving STB_HI (into CHK_LO) stops repeats immediately and clears the repeat counter. A reversal back into STB_HI does not emit a pulse and restarts the RDN delay.
  - btn stays 1 throughout.
- Undefined: the repeat counters and logic are absent, RDN/RPN are ignored, and exactly one btn_pdg pulse is produced per debounced press.

Test Plan (bench uses BN=2, DPN=8, RDN=32, RPN=8):
- Reset: hold rst=0 with btn_raw=2'b11 -> btn=0, btn_pdg=0, btn_ndg=0. Release rst with btn_raw held 11 -> btn=11 and btn_pdg=11 for one cycle, at edge 10 after the first sampling edge.
- Clean press then release on bit0: btn_raw[0] 0->1 held 20 cycles -> btn[0] rises at edge 10, btn_pdg[0] high 1 cycle. Then 1->0 -> btn[0] falls 10 edges later, btn_ndg[0] high 1 cycle.
- Bounce: btn_raw[0] toggled with high/low periods of 3,2,5,1 cycles, then held high -> btn[0] rises exactly 10 edges after the final rising edge of btn_raw[0]. Exactly one btn_pdg pulse, no btn_ndg pulse.
- Glitch rejection: btn_raw[1] high for 7 cycles (s2 stable 7 < 8), then low -> btn[1] never changes, no pulses.
- Independence: both bits pressed on the same edge -> btn_pdg=2'b11 in the same cycle. Bit1 released while bit0 bounces -> bit1 btn_ndg is unaffected.
- With BUTTON_DEBOUNCE_REPEAT_EN: hold bit0 for 80 cycles after btn[0] rises -> btn_pdg[0] pulses at +0, +32, +40, +48, ... relative to the btn rise, and stop after release. Without the macro: a single pulse only.
